// File: rtl/bcd_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants, digit type and FSM state encoding for the
//               digit-serial packed-BCD subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } bcd_state_t;

  // True when the nibble is a legal decimal digit (0..9)
  function automatic logic bcd_digit_valid(input bcd_digit_t d);
    return d < BCD_DIGIT_W'(BCD_RADIX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_subtractor_if
// Description : Start/busy/done handshake and operand/result bundle of the
//               digit-serial BCD subtractor. master = controller side,
//               slave = subtractor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_subtractor_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                        i_start;
  logic [BCD_DIGIT_W*DIGITS-1:0] i_a;
  logic [BCD_DIGIT_W*DIGITS-1:0] i_b;
  logic                        i_bin;
  logic [BCD_DIGIT_W*DIGITS-1:0] o_diff;
  logic                        o_bout;
  logic                        o_neg;
  logic                        o_busy;
  logic                        o_done;

  modport master (
    output i_start, i_a, i_b, i_bin,
    input  o_diff, o_bout, o_neg, o_busy, o_done
  );

  modport slave (
    input  i_start, i_a, i_b, i_bin,
    output o_diff, o_bout, o_neg, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/bcd_serial_subtractor_digit_sub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_sub
// Description : Combinational single-digit BCD subtract with borrow:
//               d = x - y - br_in (mod 10), br_out set when the raw
//               difference went negative.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t i_x,
  input  bcd_digit_t i_y,
  input  logic       i_br_in,
  output bcd_digit_t o_d,
  output logic       o_br_out
);

  // 5-bit raw difference; bit 4 is the sign for legal digits (-10..9)
  logic [BCD_DIGIT_W:0] w_t;

  assign w_t      = {1'b0, i_x} - {1'b0, i_y} - {{BCD_DIGIT_W{1'b0}}, i_br_in};
  assign o_br_out = w_t[BCD_DIGIT_W];
  // Adding ten modulo 16 on the low nibble equals (t + 10)[3:0]
  assign o_d      = w_t[BCD_DIGIT_W] ? (w_t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX))
                                     : w_t[BCD_DIGIT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_subtractor
// Description : Digit-serial packed-BCD subtractor, A - B - bin, one digit
//               per clock, LSD first, start/busy/done handshake.
//               Optional macro BCD_SUB_SIGN_MAG_EN: on a final borrow a
//               second pass negates the result so diff holds the magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_subtractor_if.slave bus
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_t       r_state;
  bcd_state_t       w_next_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_diff;
  logic             r_br;
  logic             r_bout;
  logic [IDX_W-1:0] r_idx;

  logic             w_last;
  logic             w_neg_pass;
  logic             w_busy;
  logic             w_done;
  bcd_digit_t       w_x;
  bcd_digit_t       w_y;
  bcd_digit_t       w_d;
  logic             w_br_out;

  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

`ifdef BCD_SUB_SIGN_MAG_EN
  assign w_neg_pass = (r_state == NEG);
`else
  assign w_neg_pass = 1'b0;
`endif

  // The negate pass computes 0 - diff through the same digit slice
  assign w_x = w_neg_pass ? '0 : r_a[BCD_DIGIT_W-1:0];
  assign w_y = w_neg_pass ? r_diff[BCD_DIGIT_W-1:0] : r_b[BCD_DIGIT_W-1:0];

  bcd_digit_sub u_digit_sub (
    .i_x      (w_x),
    .i_y      (w_y),
    .i_br_in  (r_br),
    .o_d      (w_d),
    .o_br_out (w_br_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) w_next_state = SUB;
      end
      SUB: begin
        w_busy = 1'b1;
        if (w_last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          w_next_state = w_br_out ? NEG : FIN;
`else
          w_next_state = FIN;
`endif
        end
      end
      NEG: begin
        w_busy = 1'b1;
        if (w_last) w_next_state = FIN;
      end
      FIN: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, digit shifting and result accumulation (MSD enters at top)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_a    <= bus.i_a;
            r_b    <= bus.i_b;
            r_br   <= bus.i_bin;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_idx  <= '0;
          end
        end
        SUB: begin
          r_a    <= r_a >> BCD_DIGIT_W;
          r_b    <= r_b >> BCD_DIGIT_W;
          r_diff <= (r_diff >> BCD_DIGIT_W) | (W'(w_d) << (W - BCD_DIGIT_W));
          r_br   <= w_br_out;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_idx  <= '0;
            r_bout <= w_br_out;
            r_br   <= 1'b0;
          end
        end
        NEG: begin
          r_diff <= (r_diff >> BCD_DIGIT_W) | (W'(w_d) << (W - BCD_DIGIT_W));
          r_br   <= w_br_out;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_last) r_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_diff = r_diff;
  assign bus.o_bout = r_bout;
  assign bus.o_neg  = r_bout;
  assign bus.o_busy = w_busy;
  assign bus.o_done = w_done;

`ifndef SYNTHESIS
  logic w_ops_valid;

  // Flags any non-decimal nibble on the operand buses
  always_comb begin
    w_ops_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bus.i_a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !bcd_digit_valid(bus.i_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        w_ops_valid = 1'b0;
    end
  end

  a_operands_bcd : assert property (@(posedge clk) disable iff (rst)
      (r_state == IDLE && bus.i_start) |-> w_ops_valid)
    else $error("bcd_serial_subtractor: non-BCD operand digit at start");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_subtractor
// Description : Directed-vector bench with a result scoreboard for the
//               digit-serial BCD subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = DIGITS + 1;

`ifdef BCD_SUB_SIGN_MAG_EN
  localparam logic [W-1:0] NEG_DIFF = 16'h0001;
  localparam int           NEG_LAT  = 2 * DIGITS + 1;
`else
  localparam logic [W-1:0] NEG_DIFF = 16'h9999;
  localparam int           NEG_LAT  = DIGITS + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         neg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s", nm, why);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && bus.o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_done", "done=1 required no pending result");
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", 32'(bus.o_diff), 32'(mon_e.diff));
        check("bout", 32'(bus.o_bout), 32'(mon_e.bout));
        check("neg",  32'(bus.o_neg),  32'(mon_e.neg));
      end
    end
  end

  // One operation: issue start, queue the expectation, check latency and busy
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input int lat);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_bin   = bin;
    bus.i_start = 1'b1;
    sb_q.push_back('{diff: ed, bout: eb, neg: eb});
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    n       = 0;
    seen    = 0;
    busy_ok = 1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.o_done === 1'b1) seen = 1;
      else if (n <= DIGITS && bus.o_busy !== 1'b1) busy_ok = 0;
    end
    if (!seen) fail_now("done_timeout", "no done within 40 cycles");
    else       check("latency", 32'(n), 32'(lat));
    check("busy_during_sub", 32'(busy_ok), 32'd1);
  endtask

  int n;
  int got;
  int last;
  bit seen;

  initial begin
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_diff", 32'(bus.o_diff), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_bout", 32'(bus.o_bout), 32'd0);
    check("rst_neg",  32'(bus.o_neg),  32'd0);
    rst = 1'b0;

    // Basic subtraction and output hold
    run_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, LAT);
    repeat (3) @(negedge clk);
    check("hold_diff", 32'(bus.o_diff), 32'h0667);
    check("idle_busy", 32'(bus.o_busy), 32'd0);

    // Borrow chains and borrow-in
    run_op(16'h5000, 16'h4999, 1'b0, 16'h0001, 1'b0, LAT);
    run_op(16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, LAT);

    // Negative result
    run_op(16'h0000, 16'h0001, 1'b0, NEG_DIFF, 1'b1, NEG_LAT);
    repeat (2) @(negedge clk);

    // Start while busy is ignored; operands captured at acceptance
    @(negedge clk);
    bus.i_a     = 16'h2000;
    bus.i_b     = 16'h0001;
    bus.i_bin   = 1'b0;
    bus.i_start = 1'b1;
    sb_q.push_back('{diff: 16'h1999, bout: 1'b0, neg: 1'b0});
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.o_done === 1'b1) seen = 1;
      if (n == 1) begin
        bus.i_a     = 16'h0000;
        bus.i_b     = 16'h9999;
        bus.i_bin   = 1'b1;
        bus.i_start = 1'b1;
      end
      if (n == 2) bus.i_start = 1'b0;
    end
    if (!seen) fail_now("busy_start_timeout", "no done within 40 cycles");
    else       check("busy_start_latency", 32'(n), 32'(LAT));
    repeat (10) @(negedge clk);
    check("busy_start_idle", 32'(bus.o_busy), 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.i_a     = 16'h1234;
    bus.i_b     = 16'h0567;
    bus.i_bin   = 1'b0;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_before_abort", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_diff", 32'(bus.o_diff), 32'd0);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_done", 32'(bus.o_done), 32'd0);
    check("abort_bout", 32'(bus.o_bout), 32'd0);
    check("abort_neg",  32'(bus.o_neg),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_op(16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, LAT);

    // Start held high: accepted only from IDLE, one done per 6 cycles
    repeat (2) @(negedge clk);
    bus.i_a     = 16'h9999;
    bus.i_b     = 16'h9999;
    bus.i_bin   = 1'b0;
    bus.i_start = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back('{diff: 16'h0000, bout: 1'b0, neg: 1'b0});
    n    = 0;
    got  = 0;
    last = 0;
    while (got < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.o_done === 1'b1) begin
        if (got > 0) check("b2b_interval", 32'(n - last), 32'd6);
        last = n;
        got++;
        if (got == 3) bus.i_start = 1'b0;
      end
    end
    if (got < 3) begin
      bus.i_start = 1'b0;
      fail_now("b2b_timeout", "fewer than 3 done pulses in 100 cycles");
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
